// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register with a registered in_ready. It keeps
// freeze/flush stage semantics and counts back-pressure cycles, saturating.
module pipe_skid_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_v_q,    main_v_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_v_q,    skid_v_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              push_s;
    logic              pop_s;

    // Handshake qualifiers; in_ready depends only on a flop and freeze.
    assign in_ready  = ~skid_v_q & ~freeze;
    assign out_valid = main_v_q & ~freeze;
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign stall_cnt = stall_cnt_q;

    // Next-state for the main/skid entries: flush beats freeze beats normal flow.
    always_comb begin
        main_v_d    = main_v_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_v_d    = skid_v_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            main_v_d    = 1'b0;
            main_ctrl_d = {CTRL_W{1'b0}};
            main_data_d = {DATA_W{1'b0}};
            skid_v_d    = 1'b0;
            skid_ctrl_d = {CTRL_W{1'b0}};
            skid_data_d = {DATA_W{1'b0}};
        end else if (freeze) begin
            main_v_d = main_v_q;
        end else begin
            case ({main_v_q, pop_s, push_s})
                3'b001, 3'b111: begin
                    main_v_d    = 1'b1;
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end
                3'b110: begin
                    // Skid drains into main; if skid was empty main becomes a bubble.
                    main_v_d    = skid_v_q;
                    main_ctrl_d = skid_v_q ? skid_ctrl_q : {CTRL_W{1'b0}};
                    main_data_d = skid_data_q;
                    skid_v_d    = 1'b0;
                    skid_ctrl_d = {CTRL_W{1'b0}};
                end
                3'b101: begin
                    skid_v_d    = 1'b1;
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end
                default: begin
                    main_v_d = main_v_q;
                end
            endcase
        end
    end

    // Saturating back-pressure counter; clear wins, flush has no effect.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            main_ctrl_q <= {CTRL_W{1'b0}};
            main_data_q <= {DATA_W{1'b0}};
            skid_v_q    <= 1'b0;
            skid_ctrl_q <= {CTRL_W{1'b0}};
            skid_data_q <= {DATA_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            main_v_q    <= main_v_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_v_q    <= skid_v_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a streaming vector table, hand-written corner
// sequences, then random traffic, all checked against a queue-based model.
module tb_pipe_skid_reg;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NW = 4;
    localparam int CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          rst, freeze, flush, in_valid, out_ready, cnt_clr;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cnt;

    pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        logic          iv;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic          ordy;
        logic          e_ird;
        logic          e_ov;
        logic [CW-1:0] e_c;
        logic [DW-1:0] e_d;
        logic [1:0]    e_occ;
    } vec_t;

    ent_t mq[$];
    int   mcnt;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fz, input logic fl, input logic iv, input logic [CW-1:0] c,
                         input logic [DW-1:0] d, input logic ordy, input logic clr);
        freeze = fz; flush = fl; in_valid = iv; in_ctrl = c; in_data = d;
        out_ready = ordy; cnt_clr = clr;
        #1;
    endtask

    task automatic check_model();
        int sz;
        sz = mq.size();
        chk("in_ready",  32'(in_ready),  32'(!freeze && sz < 2));
        chk("out_valid", 32'(out_valid), 32'(!freeze && sz > 0));
        chk("occupancy", 32'(occupancy), 32'(sz));
        chk("out_ctrl",  32'(out_ctrl),  (sz > 0) ? 32'(mq[0].c) : 32'd0);
        if (sz > 0) chk("out_data", out_data, mq[0].d);
        chk("stall_cnt", 32'(stall_cnt), 32'(mcnt));
    endtask

    // Advance the model by one edge from the currently driven inputs, then clock the DUT.
    task automatic tick();
        bit   push, pop;
        ent_t e;
        push = in_valid && !freeze && (mq.size() < 2);
        pop  = !freeze && (mq.size() > 0) && out_ready;
        if (cnt_clr) mcnt = 0;
        else if (!freeze && mq.size() > 0 && !out_ready && mcnt < CNT_MAX) mcnt++;
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.c = in_ctrl;
                e.d = in_data;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic fz, input logic fl, input logic iv, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic ordy, input logic clr);
        drive(fz, fl, iv, c, d, ordy, clr);
        check_model();
        tick();
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h01, 32'h11, 1'b1, 1'b1, 1'b0, 8'h00, 32'h0,  2'd0};
        tbl[1] = '{1'b1, 8'h02, 32'h12, 1'b1, 1'b1, 1'b1, 8'h01, 32'h11, 2'd1};
        tbl[2] = '{1'b1, 8'h03, 32'h13, 1'b1, 1'b1, 1'b1, 8'h02, 32'h12, 2'd1};
        tbl[3] = '{1'b1, 8'h04, 32'h14, 1'b1, 1'b1, 1'b1, 8'h03, 32'h13, 2'd1};
        tbl[4] = '{1'b1, 8'h05, 32'h15, 1'b1, 1'b1, 1'b1, 8'h04, 32'h14, 2'd1};
        tbl[5] = '{1'b0, 8'h00, 32'h0,  1'b1, 1'b1, 1'b1, 8'h05, 32'h15, 2'd1};
        tbl[6] = '{1'b0, 8'h00, 32'h0,  1'b1, 1'b1, 1'b0, 8'h00, 32'h0,  2'd0};

        rst = 1'b1;
        mcnt = 0;
        drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ctrl",  32'(out_ctrl),  32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        tick();

        // Streaming table
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, tbl[i].iv, tbl[i].c, tbl[i].d, tbl[i].ordy, 1'b0);
            chk("tbl_in_ready",  32'(in_ready),  32'(tbl[i].e_ird));
            chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].e_ov));
            chk("tbl_out_ctrl",  32'(out_ctrl),  32'(tbl[i].e_c));
            if (tbl[i].e_ov) chk("tbl_out_data", out_data, tbl[i].e_d);
            chk("tbl_occupancy", 32'(occupancy), 32'(tbl[i].e_occ));
            chk("tbl_stall_cnt", 32'(stall_cnt), 32'd0);
            check_model();
            tick();
        end

        // Back-pressure: out_ready low for cycles 3..5, then released
        step(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(8'h40 + i), 32'h20 + 32'(i), !(i >= 3 && i <= 5), 1'b0);
            if (i == 5) begin
                chk("bp_occupancy", 32'(occupancy), 32'd2);
                chk("bp_in_ready",  32'(in_ready),  32'd0);
            end
            check_model();
            tick();
        end
        chk("bp_stall_cnt", 32'(stall_cnt), 32'd3);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0);

        // Flush with two entries held and a payload in flight
        step(1'b0, 1'b0, 1'b1, 8'hA1, 32'hA1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hA2, 32'hA2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hEE, 32'hEE, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_out_ctrl",  32'(out_ctrl),  32'd0);
        chk("fl_occupancy", 32'(occupancy), 32'd0);
        chk("fl_in_ready",  32'(in_ready),  32'd1);
        check_model();
        tick();

        // Freeze for three cycles at occupancy 1
        step(1'b0, 1'b0, 1'b1, 8'h5A, 32'h55, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'h66, 32'h66, 1'b1, 1'b0);
            chk("fz_out_valid", 32'(out_valid), 32'd0);
            chk("fz_in_ready",  32'(in_ready),  32'd0);
            check_model();
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0);
        chk("fz_rel_valid", 32'(out_valid), 32'd1);
        chk("fz_rel_data",  out_data,       32'h55);
        check_model();
        tick();
        step(1'b0, 1'b0, 1'b1, 8'h77, 32'h77, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h78, 32'h78, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0);
        chk("fzfl_occupancy", 32'(occupancy), 32'd0);
        chk("fzfl_out_valid", 32'(out_valid), 32'd0);
        check_model();
        tick();

        // Counter saturation then clear
        step(1'b0, 1'b0, 1'b1, 8'h99, 32'h99, 1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
        step(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b1);
        chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges at occupancy 2
        step(1'b0, 1'b0, 1'b1, 8'hB1, 32'hB1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hB2, 32'hB2, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_occupancy", 32'(occupancy), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_ctrl",  32'(out_ctrl),  32'd0);
        chk("arst_out_data",  out_data,       32'd0);
        chk("arst_occupancy", 32'(occupancy), 32'd0);
        chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        mq.delete();
        mcnt = 0;
        #1;
        rst = 1'b0;
        tick();
        step(1'b0, 1'b0, 1'b1, 8'hCD, 32'hAB, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
        chk("arst_push_valid", 32'(out_valid), 32'd1);
        chk("arst_push_data",  out_data,       32'hAB);
        check_model();
        tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0, 1'($urandom),
                 8'($urandom), $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised successor to the fixed-field inter-stage pipeline registers. It is a two-entry elastic pipeline stage that carries a generic payload, split into CTRL_W control bits and DATA_W datapath bits, between any two stages of the core. Upstream and downstream use a valid/ready handshake, and `in_ready` is fully registered, so there is no combinational path from `out_ready` to `in_ready`. The block keeps the existing freeze (stall) and flush (bubble-insert) semantics and adds a saturating back-pressure counter for performance monitoring.

## Interface
- `DATA_W`, default 32: width of the datapath payload (operands, PC, immediates).
- `CTRL_W`, default 8: width of the control payload (wb_en, mem_read, mem_write, branch, etc.). These bits are forced to zero on flush.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `freeze`, in, 1: hold all state; blocks both handshakes.
- `flush`, in, 1: discard all held entries (insert a bubble).
- `in_valid`, in, 1: upstream presents a payload.
- `in_ready`, out, 1: stage can accept a payload.
- `in_ctrl`, in, CTRL_W: upstream control payload.
- `in_data`, in, DATA_W: upstream datapath payload.
- `out_valid`, out, 1: downstream payload is valid.
- `out_ready`, in, 1: downstream accepts the payload.
- `out_ctrl`, out, CTRL_W: control payload of the head entry.
- `out_data`, out, DATA_W: datapath payload of the head entry.
- `occupancy`, out, 2: number of held entries (0 to 2).
- `cnt_clr`, in, 1: synchronous clear of `stall_cnt`.
- `stall_cnt`, out, CNT_W: cycles with `out_valid & ~out_ready`, saturating.

## Operation
- Storage consists of a main entry (`main_v`, `main_ctrl`, `main_data`) and a skid entry (`skid_v`, `skid_ctrl`, `skid_data`). The outputs always reflect the main entry.
- `in_ready = ~skid_v & ~freeze`. `skid_v` comes from a flop, so no combinational path exists from `out_ready`.
- `out_valid = main_v & ~freeze`.
- Handshakes:
  - Push occurs when `in_valid & in_ready`.
  - Pop occurs when `out_valid & out_ready`.
- Priority per cycle, highest first: `rst` > `flush` > `freeze` > normal operation.
- Flush:
  - Clears `main_v` and `skid_v`, and zeroes all ctrl and data fields of both entries.
  - Any push or pop in the same cycle is discarded.
  - Flush overrides freeze.
- Freeze: no entry state changes.
- Normal operation, enumerated by (main_v, skid_v, push, pop):
  - main empty, push: main <= in.
  - main full, pop, push: main <= in.
  - main full, pop, no push, skid full: main <= skid, and skid is cleared. No push can occur here because `in_ready` = 0.
  - main full, pop, no push, skid empty: main is cleared.
  - main full, no pop, push: skid <= in.
  - main full, no pop, no push: hold.
- When an entry is cleared by a pop, its ctrl field is zeroed. Its data field is don't-care.
- `occupancy = main_v + skid_v`. The invariant `skid_v -> main_v` must always hold.
- Stall counter:
  - `cnt_clr` has priority and loads 0.
  - Otherwise it increments when `out_valid & ~out_ready`.
  - It saturates at 2^CNT_W-1.
  - It is unaffected by `flush`; while `freeze` = 1 it does not increment, because `out_valid` = 0.

## Timing
- Reset values: `out_valid` 0, `out_ctrl` 0, `out_data` 0, `occupancy` 0, `stall_cnt` 0. `in_ready` is 1 unless `freeze` = 1.
- Latency is 1 cycle: a payload pushed at edge N appears on `out_*` with `out_valid` = 1 after edge N.
- Throughput is 1 payload per cycle while `out_ready` is held high, with occupancy settling at 1.
- After `out_ready` deasserts, the stage absorbs exactly one more payload (into the skid entry). `in_ready` then drops in the following cycle.
- After `out_ready` re-asserts with occupancy 2:
  - The skid entry drains to main at the first pop edge.
  - `in_ready` returns to 1 in the cycle after that edge.
- Flush at edge N: `out_valid` = 0, `out_ctrl` = 0, and `occupancy` = 0 from edge N onward. `in_ready` = 1 in the cycle after (unless frozen).
- `rst` asserted mid-transfer clears everything immediately, without waiting for a clock edge.
- `freeze`, `in_ready` and `out_valid` interact combinationally within the same cycle; all other outputs change only at edges.

## Test plan
- **Streaming:** push payloads 0x11 to 0x15 on consecutive cycles with `out_ready` = 1 -> each appears 1 cycle later, in order. Occupancy ≤ 1 throughout; `stall_cnt` = 0.
- **Back-pressure:** stream data with `out_ready` = 0 from cycle 3 -> exactly 2 entries are held and `in_ready` = 0. Release for 4 cycles -> no loss or duplication; `stall_cnt` equals the number of cycles `out_ready` was held low while `out_valid` = 1.
- **Flush with 2 entries and `in_valid` = 1:** -> the next cycle shows `out_valid` = 0, `out_ctrl` = 0, `occupancy` = 0, and the in-flight payload is dropped.
- **Freeze for 3 cycles with occupancy 1 and `out_ready` = 1:** -> `out_valid` = 0 and `in_ready` = 0 throughout; the same payload is presented after the freeze releases. Flush asserted during a freeze still clears the stage.
- **Counter saturation:** with `CNT_W` = 4, hold the stall condition for 20 cycles -> `stall_cnt` = 15. Pulse `cnt_clr` -> 0.
- **Asynchronous reset:** assert `rst` between clock edges at occupancy 2 -> all outputs reach their reset values immediately. Release `rst`, then push 0xAB -> 0xAB is output after 1 cycle.
